// File: rtl/mem_req_pkg.sv
// Shared definitions for the PSRAM request sequencer: FSM encoding and the queued command record.
// The command record is the unit held in the in-order command FIFO.
package mem_req_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2,
      RETIRE    = 2'd3
   } state_e;

   localparam int ADDR_W_DEF = 24;

   typedef struct packed {
      logic                  write;
      logic [ADDR_W_DEF-1:0] address;
      logic [7:0]            wdata;
   } cmd_t;

   function automatic int cmd_width(input int addr_w);
      return 1 + addr_w + 8;
   endfunction

   localparam int CMD_W = cmd_width(ADDR_W_DEF);

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous in-order FIFO, fall-through head, registered full/empty flags.
// A push while full is dropped unless a pop frees a slot in the same cycle.
module mem_req_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic [PTR_W:0]   w_count_nxt;
   logic             r_full;
   logic             r_empty;
   logic             w_push;
   logic             w_pop;

   assign w_pop  = i_pop & ~r_empty;
   assign w_push = i_push & (~r_full | w_pop);

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   // Depth is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == FULL_CNT);
         r_empty <= (w_count_nxt == '0);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_din;
   end

   assign o_dout  = r_mem[r_rd_ptr];
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

// File: rtl/mem_req_sequencer.sv
// Queues byte requests and replays them one at a time on the PSRAM controller strobe/busy port.
// 3 cycles of overhead per access plus controller busy time; o_req_ready drops only when the FIFO is full.
module mem_req_sequencer
   import mem_req_pkg::*;
#(
   parameter int FIFO_DEPTH    = 4,
   parameter int ADDR_W        = 24,
   parameter int ISSUE_TIMEOUT = 15
) (
   input  logic              i_clkRAM,
   input  logic              reset,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_write,
   input  logic [ADDR_W-1:0] i_req_address,
   input  logic [7:0]        i_req_wdata,
   output logic              o_rd_valid,
   output logic [7:0]        o_rd_data,
   output logic              o_mem_cs,
   output logic              o_mem_write,
   output logic [ADDR_W-1:0] o_mem_address,
   output logic [7:0]        o_mem_dataToWrite,
   input  logic              i_mem_busy,
   input  logic              i_mem_dataReady,
   input  logic [7:0]        i_mem_dataRead,
   output logic              o_error,
   output logic              o_pending
);

   localparam int W_CMD = cmd_width(ADDR_W);
   localparam int TMO_W = $clog2(ISSUE_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ISSUE_TIMEOUT - 1);

   state_e             r_state;
   logic [TMO_W-1:0]   r_tmo;
   logic               r_cs;
   logic               r_write;
   logic [ADDR_W-1:0]  r_addr;
   logic [7:0]         r_wdata;
   logic               r_rd_valid;
   logic [7:0]         r_rd_data;
   logic               r_error;
   logic [W_CMD-1:0]   w_fifo_din;
   logic [W_CMD-1:0]   w_fifo_dout;
   logic               w_fifo_full;
   logic               w_fifo_empty;
   logic               w_push;
   logic               w_pop;

   assign w_push     = i_req_valid & ~w_fifo_full;
   assign w_fifo_din = {i_req_write, i_req_address, i_req_wdata};
   // Controller busy in IDLE means it is still initialising; hold the queue.
   assign w_pop      = (r_state == IDLE) & ~w_fifo_empty & ~i_mem_busy;

   mem_req_fifo #(
      .WIDTH (W_CMD),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clkRAM),
      .i_reset (reset),
      .i_push  (w_push),
      .i_din   (w_fifo_din),
      .i_pop   (w_pop),
      .o_dout  (w_fifo_dout),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   always_ff @(posedge i_clkRAM) begin
      if (reset) begin
         r_state    <= IDLE;
         r_tmo      <= '0;
         r_cs       <= 1'b1;
         r_write    <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_error    <= 1'b0;
      end else begin
         r_rd_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_write <= w_fifo_dout[W_CMD-1];
                  r_addr  <= w_fifo_dout[8 +: ADDR_W];
                  r_wdata <= w_fifo_dout[7:0];
                  r_cs    <= 1'b0;
                  r_tmo   <= '0;
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
               if (i_mem_busy) begin
                  r_cs    <= 1'b1;
                  r_state <= WAIT_DONE;
               end else if (r_tmo == TMO_LAST) begin
                  // Controller never acknowledged: drop the request, flag it.
                  r_error <= 1'b1;
                  r_cs    <= 1'b1;
                  r_state <= IDLE;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!i_mem_busy) begin
                  if (r_write) begin
                     r_state <= RETIRE;
                  end else if (i_mem_dataReady) begin
                     r_rd_data  <= i_mem_dataRead;
                     r_rd_valid <= 1'b1;
                     r_state    <= RETIRE;
                  end
               end
            end
            RETIRE:  r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_req_ready       = ~w_fifo_full;
   assign o_rd_valid        = r_rd_valid;
   assign o_rd_data         = r_rd_data;
   assign o_mem_cs          = r_cs;
   assign o_mem_write       = r_write;
   assign o_mem_address     = r_addr;
   assign o_mem_dataToWrite = r_wdata;
   assign o_error           = r_error;
   assign o_pending         = ~w_fifo_empty | (r_state != IDLE);

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Directed bench for mem_req_sequencer with a behavioural PSRAM controller model.
module tb_mem_req_sequencer;

   logic        i_clkRAM = 1'b0;
   logic        reset = 1'b1;
   logic        i_req_valid = 1'b0;
   logic        o_req_ready;
   logic        i_req_write = 1'b0;
   logic [23:0] i_req_address = '0;
   logic [7:0]  i_req_wdata = '0;
   logic        o_rd_valid;
   logic [7:0]  o_rd_data;
   logic        o_mem_cs;
   logic        o_mem_write;
   logic [23:0] o_mem_address;
   logic [7:0]  o_mem_dataToWrite;
   logic        i_mem_busy = 1'b0;
   logic        i_mem_dataReady = 1'b0;
   logic [7:0]  i_mem_dataRead = '0;
   logic        o_error;
   logic        o_pending;

   bit          mdl_init = 1'b1;
   bit          mdl_never = 1'b0;
   int          mdl_lat = 5;
   int          mdl_gap = 0;
   logic [7:0]  mem_model [logic [23:0]];

   int          n_cmp = 0;
   int          n_err = 0;
   int          rd_cycles = 0;
   logic [7:0]  last_rd = '0;
   logic [32:0] issue_q [$];
   int          hi_run = 0;
   int          lo_run = 0;
   int          last_gap = 0;
   int          last_low = 0;
   int          side_chg = 0;

   mem_req_sequencer #(
      .FIFO_DEPTH    (4),
      .ADDR_W        (24),
      .ISSUE_TIMEOUT (15)
   ) dut (
      .i_clkRAM          (i_clkRAM),
      .reset             (reset),
      .i_req_valid       (i_req_valid),
      .o_req_ready       (o_req_ready),
      .i_req_write       (i_req_write),
      .i_req_address     (i_req_address),
      .i_req_wdata       (i_req_wdata),
      .o_rd_valid        (o_rd_valid),
      .o_rd_data         (o_rd_data),
      .o_mem_cs          (o_mem_cs),
      .o_mem_write       (o_mem_write),
      .o_mem_address     (o_mem_address),
      .o_mem_dataToWrite (o_mem_dataToWrite),
      .i_mem_busy        (i_mem_busy),
      .i_mem_dataReady   (i_mem_dataReady),
      .i_mem_dataRead    (i_mem_dataRead),
      .o_error           (o_error),
      .o_pending         (o_pending)
   );

   always #5 i_clkRAM = ~i_clkRAM;

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Controller model: busy one cycle after the strobe, memory-backed reads, optional dataReady gap.
   initial begin : ctrl_model
      int          phase;
      int          cnt;
      int          gcnt;
      logic        m_wr;
      logic [23:0] m_a;
      logic [7:0]  m_d;
      phase = 0; cnt = 0; gcnt = 0; m_wr = 1'b0; m_a = '0; m_d = '0;
      forever begin
         @(negedge i_clkRAM);
         #1;
         i_mem_dataReady = 1'b0;
         i_mem_dataRead  = 8'hEE;
         if (reset || mdl_init) begin
            phase = 0;
            i_mem_busy = mdl_init;
         end else begin
            case (phase)
               0: begin
                  i_mem_busy = 1'b0;
                  if (!mdl_never && !o_mem_cs) begin
                     m_wr = o_mem_write; m_a = o_mem_address; m_d = o_mem_dataToWrite;
                     i_mem_busy = 1'b1; cnt = mdl_lat; phase = 1;
                  end
               end
               1: begin
                  cnt--;
                  if (cnt <= 0) begin
                     i_mem_busy = 1'b0;
                     if (m_wr) begin
                        mem_model[m_a] = m_d; phase = 0;
                     end else if (mdl_gap == 0) begin
                        i_mem_dataReady = 1'b1;
                        i_mem_dataRead  = mem_model.exists(m_a) ? mem_model[m_a] : 8'h00;
                        phase = 0;
                     end else begin
                        gcnt = mdl_gap; phase = 2;
                     end
                  end
               end
               default: begin
                  gcnt--;
                  if (gcnt <= 0) begin
                     i_mem_dataReady = 1'b1;
                     i_mem_dataRead  = mem_model.exists(m_a) ? mem_model[m_a] : 8'h00;
                     phase = 0;
                  end
               end
            endcase
         end
      end
   end

   initial begin : monitor
      logic        p_cs;
      logic [32:0] p_side;
      logic [32:0] side;
      logic        fall;
      p_cs = 1'b1; p_side = '0;
      forever begin
         @(posedge i_clkRAM);
         #1;
         side = {o_mem_write, o_mem_address, o_mem_dataToWrite};
         fall = p_cs && !o_mem_cs;
         if (fall) begin
            issue_q.push_back(side);
            last_gap = hi_run;
         end
         if (!reset && !fall && side != p_side) side_chg++;
         if (o_mem_cs) begin
            if (!p_cs) last_low = lo_run;
            hi_run++; lo_run = 0;
         end else begin
            lo_run++; hi_run = 0;
         end
         if (o_rd_valid) begin
            rd_cycles++; last_rd = o_rd_data;
         end
         p_cs = o_mem_cs; p_side = side;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic w, input logic [23:0] a, input logic [7:0] d);
      int t = 0;
      while (!o_req_ready && t < 500) begin
         @(negedge i_clkRAM); t++;
      end
      if (!o_req_ready) check("push_ready_timeout", 64'(o_req_ready), 64'd1);
      i_req_valid = 1'b1; i_req_write = w; i_req_address = a; i_req_wdata = d;
      @(negedge i_clkRAM);
      i_req_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int t = 0;
      while (o_pending && t < budget) begin
         @(negedge i_clkRAM); t++;
      end
      check(tag, 64'(o_pending), 64'd0);
      repeat (2) @(negedge i_clkRAM);
   endtask

   initial begin : stimulus
      int rd0;
      int iq0;
      int t;
      int lc;
      repeat (3) @(negedge i_clkRAM);
      check("rst_cs", 64'(o_mem_cs), 64'd1);
      check("rst_write", 64'(o_mem_write), 64'd0);
      check("rst_addr", 64'(o_mem_address), 64'd0);
      check("rst_wdata", 64'(o_mem_dataToWrite), 64'd0);
      check("rst_rd_valid", 64'(o_rd_valid), 64'd0);
      check("rst_rd_data", 64'(o_rd_data), 64'd0);
      check("rst_error", 64'(o_error), 64'd0);
      check("rst_pending", 64'(o_pending), 64'd0);
      check("rst_ready", 64'(o_req_ready), 64'd1);
      reset = 1'b0;

      // Controller init: busy held high, the queued write must wait.
      push(1'b1, 24'h00AAAA, 8'hF0);
      lc = 0;
      repeat (100) begin
         @(negedge i_clkRAM);
         if (!o_mem_cs) lc++;
      end
      check("init_cs_held", 64'(lc), 64'd0);
      check("init_pending", 64'(o_pending), 64'd1);
      mdl_init = 1'b0;
      @(negedge i_clkRAM);
      check("init_issue_cs", 64'(o_mem_cs), 64'd0);
      check("init_issue_addr", 64'(o_mem_address), 64'h00AAAA);
      check("init_issue_write", 64'(o_mem_write), 64'd1);
      check("init_issue_wdata", 64'(o_mem_dataToWrite), 64'hF0);
      wait_idle(200, "init_idle");

      // Read return with 20-cycle busy.
      mdl_lat = 20; rd0 = rd_cycles;
      push(1'b0, 24'h00AAAA, 8'h00);
      wait_idle(200, "rd_idle");
      check("rd_pulse_cycles", 64'(rd_cycles - rd0), 64'd1);
      check("rd_pulse_data", 64'(last_rd), 64'hF0);
      check("rd_data_held", 64'(o_rd_data), 64'hF0);

      // Full FIFO while the controller is busy.
      mdl_init = 1'b1; mdl_lat = 30; iq0 = issue_q.size();
      @(negedge i_clkRAM);
      check("full_ready_before", 64'(o_req_ready), 64'd1);
      for (int i = 0; i < 4; i++) push(1'b1, 24'h000100 + 24'(i), 8'h11 + 8'(i));
      check("full_ready_low", 64'(o_req_ready), 64'd0);
      i_req_valid = 1'b1; i_req_write = 1'b1; i_req_address = 24'h000104; i_req_wdata = 8'h15;
      repeat (5) @(negedge i_clkRAM);
      check("full_5th_blocked", 64'(o_req_ready), 64'd0);
      check("full_no_issue", 64'(issue_q.size() - iq0), 64'd0);
      mdl_init = 1'b0;
      t = 0;
      while (!o_req_ready && t < 50) begin
         @(negedge i_clkRAM); t++;
      end
      check("full_pop_first", 64'(issue_q.size() - iq0), 64'd1);
      @(negedge i_clkRAM);
      i_req_valid = 1'b0;
      wait_idle(1000, "full_idle");
      check("full_issue_count", 64'(issue_q.size() - iq0), 64'd5);
      for (int i = 0; i < 5; i++)
         if (iq0 + i < issue_q.size())
            check($sformatf("full_order%0d", i), 64'(issue_q[iq0 + i]),
                  64'({1'b1, 24'h000100 + 24'(i), 8'h11 + 8'(i)}));

      // Timeout: controller never raises busy.
      mdl_never = 1'b1; rd0 = rd_cycles; iq0 = issue_q.size();
      check("tmo_error_clear", 64'(o_error), 64'd0);
      push(1'b0, 24'h123456, 8'h00);
      wait_idle(100, "tmo_idle");
      check("tmo_issued", 64'(issue_q.size() - iq0), 64'd1);
      check("tmo_cs_low_len", 64'(last_low), 64'd15);
      check("tmo_error_set", 64'(o_error), 64'd1);
      check("tmo_no_rd", 64'(rd_cycles - rd0), 64'd0);
      mdl_never = 1'b0;
      push(1'b1, 24'h000020, 8'h77);
      wait_idle(100, "tmo_next_idle");
      check("tmo_next_issue", 64'(issue_q[$]), 64'({1'b1, 24'h000020, 8'h77}));
      check("tmo_error_sticky", 64'(o_error), 64'd1);

      // Reset in WAIT_DONE of a read, with a second read still queued.
      mdl_lat = 20; rd0 = rd_cycles; iq0 = issue_q.size();
      push(1'b0, 24'h000030, 8'h00);
      push(1'b0, 24'h000031, 8'h00);
      t = 0;
      while (!i_mem_busy && t < 50) begin
         @(negedge i_clkRAM); t++;
      end
      repeat (3) @(negedge i_clkRAM);
      check("rstmid_pending_before", 64'(o_pending), 64'd1);
      reset = 1'b1;
      @(negedge i_clkRAM);
      check("rstmid_cs", 64'(o_mem_cs), 64'd1);
      check("rstmid_pending", 64'(o_pending), 64'd0);
      check("rstmid_ready", 64'(o_req_ready), 64'd1);
      check("rstmid_rd_valid", 64'(o_rd_valid), 64'd0);
      reset = 1'b0;
      repeat (40) @(negedge i_clkRAM);
      check("rstmid_no_rd", 64'(rd_cycles - rd0), 64'd0);
      check("rstmid_one_issue", 64'(issue_q.size() - iq0), 64'd1);
      check("rstmid_error_cleared", 64'(o_error), 64'd0);

      // Ordering: read behind a write to the same address.
      mdl_lat = 3; rd0 = rd_cycles; iq0 = issue_q.size();
      push(1'b1, 24'h000010, 8'h55);
      push(1'b0, 24'h000010, 8'h00);
      wait_idle(200, "ord_idle");
      check("ord_rd_data", 64'(last_rd), 64'h55);
      check("ord_rd_cycles", 64'(rd_cycles - rd0), 64'd1);
      check("ord_two_issues", 64'(issue_q.size() - iq0), 64'd2);
      check("ord_cs_gap", 64'(last_gap >= 1), 64'd1);

      // dataReady lags the busy drop by 3 cycles.
      mdl_gap = 3; rd0 = rd_cycles;
      push(1'b1, 24'h000040, 8'h3C);
      push(1'b0, 24'h000040, 8'h00);
      wait_idle(200, "gap_idle");
      check("gap_rd_data", 64'(last_rd), 64'h3C);
      check("gap_rd_cycles", 64'(rd_cycles - rd0), 64'd1);
      check("gap_rd_held", 64'(o_rd_data), 64'h3C);

      check("side_outputs_stable", 64'(side_chg), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
